// File: rtl/dac_spi_pkg.sv
// Shared types and sizing helpers for the DAC SPI transmitter.
package dac_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT_HI,
      ST_SHIFT_LO,
      ST_HOLD
   } state_t;

   // Length of one SPI frame: command prefix followed by the sample.
   function automatic int frame_len(input int ctrl_bits, input int io_width);
      return ctrl_bits + io_width;
   endfunction

   // Width of the half-period divider counter.
   function automatic int div_cnt_w(input int clk_div);
      return $clog2(clk_div + 1);
   endfunction

   // Width of the bit counter; it must be able to hold the full frame length.
   function automatic int bit_cnt_w(input int frame);
      return $clog2(frame + 1);
   endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// Half-period timer: tick is high in the last clk cycle of every D-cycle phase.
module dac_spi_tick
   import dac_spi_pkg::*;
#(
   parameter int pw_clk_div = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int lpw_cnt = div_cnt_w(pw_clk_div);

   logic [lpw_cnt-1:0] cnt;

   assign tick = (cnt == lpw_cnt'(pw_clk_div - 1));

   // Count cycles within the current phase; restart marks the first cycle of a new phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (restart || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises filtered samples as {command, offset-binary sample} frames to an SPI mode-0 DAC.
// One sample can wait in a pending buffer while a frame is on the wire; a lost sample sets o_overrun.
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int                      pw_io_width  = 12,
   parameter int                      pw_ctrl_bits = 4,
   parameter logic [pw_ctrl_bits-1:0] pw_ctrl_word = 4'b0011,
   parameter int                      pw_clk_div   = 4
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ce,
   input  logic signed [pw_io_width-1:0] isp_in,
   input  logic                          i_overrun_clr,
   output logic                          o_sclk,
   output logic                          o_cs_n,
   output logic                          o_mosi,
   output logic                          o_busy,
   output logic                          o_overrun
);

   localparam int lpw_frame = frame_len(pw_ctrl_bits, pw_io_width);
   localparam int lpw_bit   = bit_cnt_w(lpw_frame);

   // Two's complement to offset binary is a flip of the sign bit.
   function automatic logic [lpw_frame-1:0] to_frame(input logic signed [pw_io_width-1:0] s);
      return {pw_ctrl_word, ~s[pw_io_width-1], s[pw_io_width-2:0]};
   endfunction

   state_t               state, state_next;
   logic [lpw_bit-1:0]   bit_cnt;
   logic [lpw_frame-1:0] shreg, pend_word, word_in;
   logic                 start, pend_vld, tick, restart;
   logic                 hold_end, accept, consume, store, lost;
   logic                 sclk_next, cs_n_next, mosi_next, busy_next;

   assign word_in  = to_frame(isp_in);
   assign hold_end = (state == ST_HOLD) && tick;
   // A sample starts a frame directly when the line is free (IDLE, or HOLD ending with nothing queued).
   assign accept   = ce && (((state == ST_IDLE) && !start) || (hold_end && !pend_vld));
   assign consume  = hold_end && pend_vld;
   assign store    = ce && !accept;
   // Storing over a queued word that is not being handed to the shifter this cycle loses it.
   assign lost     = store && pend_vld && !consume;
   assign restart  = (state_next != state);

   dac_spi_tick #(.pw_clk_div(pw_clk_div)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   // Next state and next registered SPI line values.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:     if (start) state_next = ST_SETUP;
         ST_SETUP:    if (tick)  state_next = ST_SHIFT_HI;
         ST_SHIFT_HI: if (tick)  state_next = ST_SHIFT_LO;
         ST_SHIFT_LO: if (tick)  state_next = (bit_cnt == lpw_bit'(lpw_frame)) ? ST_HOLD : ST_SHIFT_HI;
         ST_HOLD:     if (tick)  state_next = pend_vld ? ST_SETUP : ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase

      sclk_next = (state_next == ST_SHIFT_HI);
      cs_n_next = !((state_next == ST_SETUP) || (state_next == ST_SHIFT_HI) ||
                    (state_next == ST_SHIFT_LO));
      busy_next = (state_next != ST_IDLE);

      mosi_next = o_mosi;
      if ((state_next == ST_SETUP) && (state != ST_SETUP))
         mosi_next = consume ? pend_word[lpw_frame-1] : shreg[lpw_frame-1];
      else if ((state_next == ST_SHIFT_LO) && (state == ST_SHIFT_HI))
         mosi_next = (bit_cnt == lpw_bit'(lpw_frame - 1)) ? 1'b0 : shreg[lpw_frame-2];
      else if ((state_next == ST_HOLD) || (state_next == ST_IDLE))
         mosi_next = 1'b0;
   end

   // Control state, SPI outputs, pending flag and overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         o_sclk    <= 1'b0;
         o_cs_n    <= 1'b1;
         o_mosi    <= 1'b0;
         o_busy    <= 1'b0;
         o_overrun <= 1'b0;
         start     <= 1'b0;
         pend_vld  <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         state  <= state_next;
         o_sclk <= sclk_next;
         o_cs_n <= cs_n_next;
         o_mosi <= mosi_next;
         o_busy <= busy_next;
         start  <= accept;

         if (store)
            pend_vld <= 1'b1;
         else if (consume)
            pend_vld <= 1'b0;

         if (state_next == ST_SETUP)
            bit_cnt <= '0;
         else if ((state == ST_SHIFT_HI) && (state_next == ST_SHIFT_LO))
            bit_cnt <= bit_cnt + 1'b1;

         if (lost)
            o_overrun <= 1'b1;
         else if (i_overrun_clr)
            o_overrun <= 1'b0;
      end
   end

   // Frame shift register and pending word; their contents only matter once qualified by control.
   always_ff @(posedge clk) begin
      if (accept)
         shreg <= word_in;
      else if (consume)
         shreg <= pend_word;
      else if ((state == ST_SHIFT_HI) && (state_next == ST_SHIFT_LO))
         shreg <= shreg << 1;

      if (store)
         pend_word <= word_in;
   end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Downstream stage of the 8th-order FIR filter.
- Takes each filtered signed sample, qualified by the same ce strobe that clocks the filter, and converts it to offset binary.
- Prefixes a fixed DAC command nibble and shifts the frame MSB-first to a serial DAC over SPI mode 0.
- Holds one pending sample while a frame is in flight and flags lost samples.

Parameters:
pw_io_width, 12, sample width; must match the filter output width
pw_ctrl_bits, 4, width of the command prefix
pw_ctrl_word, 4'b0011, command prefix (write-and-update)
pw_clk_div, 4, SCLK half-period in clk cycles; minimum 1
lpw_frame (local), pw_ctrl_bits+pw_io_width = 16, frame length

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ce  in  1  sample strobe; single-cycle, aligned with isp_in valid
isp_in  in  pw_io_width  signed two's-complement sample from the filter
i_overrun_clr  in  1  clears o_overrun
o_sclk  out  1  SPI clock; idles low
o_cs_n  out  1  SPI chip select, active low
o_mosi  out  1  SPI data; changes on the SCLK falling edge
o_busy  out  1  frame in progress
o_overrun  out  1  sticky flag: a sample was lost

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately and also mid-frame: o_sclk=0, o_cs_n=1, o_mosi=0, o_busy=0, o_overrun=0; pending buffer empty; state IDLE. No partial frame resumes after reset.
- Frame word:
  - {pw_ctrl_word, isp_in with MSB inverted} (offset binary).
  - 0x800 maps to 0x000, 0x7FF to 0xFFF, 0x000 to 0x800.
  - Word is latched on the accepting clk edge.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD. D = pw_clk_div.
- IDLE:
  - o_busy=0.
  - ce at edge k latches the word.
  - At edge k+1: state=SETUP, o_cs_n=0, o_sclk=0, o_mosi=frame MSB, o_busy=1.
- SETUP: D cycles, then SHIFT_HI.
- SHIFT_HI: o_sclk=1 for D cycles. The DAC samples on the rising edge.
- SHIFT_LO:
  - o_sclk=0 for D cycles.
  - On entry, o_mosi advances to the next bit, or goes to 0 after the last bit.
  - After the low phase of bit lpw_frame-1, go to HOLD.
- HOLD: o_cs_n=1, o_mosi=0 for D cycles.
  - If pending is valid at HOLD end: go directly to SETUP with the pending word and clear pending.
  - Otherwise go to IDLE.
- Timing: o_cs_n low for (2*lpw_frame+1)*D cycles (132 at defaults). o_busy high for (2*lpw_frame+2)*D cycles per frame (136).
- ce while o_busy=1 and pending empty: word stored in pending.
- ce while o_busy=1 and pending full: pending overwritten with the newer word; o_overrun set. The older word is lost.
- ce on the cycle that HOLD ends with pending empty: the design is in IDLE-equivalent state, so the sample is accepted as a new frame. No overrun.
- o_overrun stays set until i_overrun_clr. Set and clear in the same cycle: set wins.
- Divider counter: width $clog2(pw_clk_div+1); reloads on every state or phase change.
- Bit counter: width $clog2(lpw_frame+1).

Decomposition:
- Package dac_spi_pkg: state enumeration, lpw_frame constant, counter-width functions.
- One sub-module, dac_spi_tick: a D-cycle half-period counter with a restart input and a single-cycle tick output, consumed by the FSM.
- Shift register, pending buffer and overrun logic stay in the top module.

Test Plan:
1. Reset, then a single ce with isp_in=12'h000 -> o_cs_n falls 1 cycle later. Captured frame on SCLK rising edges = 16'h3800. o_cs_n low 132 cycles, o_busy high 136 cycles, o_overrun=0.
2. isp_in=12'h7FF, then after IDLE isp_in=12'h800 -> frames 16'h3FFF and 16'h3000. MOSI is stable across every SCLK rising edge.
3. Second ce with 12'h123 at cycle 20 of a frame -> frame with 12'h123 starts right after HOLD, with no IDLE gap. o_overrun=0.
4. Two ces during one frame (12'h111, then 12'h222) -> next frame carries 12'h222 (payload 16'h3A22), o_overrun=1. Assert i_overrun_clr on the same cycle as a third losing ce -> o_overrun stays 1. A later lone clear -> 0.
5. Assert rst at cycle 50 of a frame -> o_cs_n=1 and o_sclk=0 without waiting for a clk edge; pending discarded. Next ce produces a complete, correct frame.
6. pw_clk_div=1 build, back-to-back ces every 34 cycles -> continuous frames of 34 busy cycles each. No overrun, all data correct.
